// File: rtl/bp_line_loader_if.sv
// Loader-side bus: job config, DDR command/FIFO handshake and BP buffer write port.
// master = the loader, slave = the surrounding environment.
interface bp_line_loader_if #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int LINE_LEN     = 8
);
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int BANK_W     = (X_MAC > 1) ? $clog2(X_MAC) : 1;

  logic                           conf;
  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr;
  logic [ADDR_LEN-1:0]            bp_st_addr;
  logic [BANK_W-1:0]              bp_st_bank;
  logic [SINGLE_LEN-1:0]          line_width;
  logic [LINE_LEN-1:0]            line_num;
  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]          ddr_len;
  logic                           ddr_conf;
  logic                           ddr_fifo_empty;
  logic                           ddr_fifo_req;
  logic [DATA_LEN*X_MESH-1:0]     ddr_fifo_data;
  logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out;
  logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_out;
  logic [BUFFER_NUM-1:0]          BP_wea;
  logic                           busy;
  logic                           done;
  logic                           conf_err;

  modport master (
    input  conf, ddr_st_addr, bp_st_addr, bp_st_bank, line_width, line_num,
           ddr_fifo_empty, ddr_fifo_data,
    output ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req,
           BP_addr_out, BP_data_out, BP_wea, busy, done, conf_err
  );

  modport slave (
    output conf, ddr_st_addr, bp_st_addr, bp_st_bank, line_width, line_num,
           ddr_fifo_empty, ddr_fifo_data,
    input  ddr_st_addr_out, ddr_len, ddr_conf, ddr_fifo_req,
           BP_addr_out, BP_data_out, BP_wea, busy, done, conf_err
  );
endinterface

// File: rtl/bp_line_loader.sv
// DDR->BP buffer line loader: issues one DDR read per job, then streams FIFO words into
// the bank groups line by line, advancing the base address each time the banks wrap.
module bp_line_loader #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int LINE_LEN     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bp_line_loader_if.master bus
);
  localparam int BUFFER_NUM = X_MAC * X_MESH;
  localparam int WORD_BYTES = DATA_LEN * X_MESH / 8;
  localparam int BANK_W     = (X_MAC > 1) ? $clog2(X_MAC) : 1;
  localparam int TOT_W      = SINGLE_LEN + LINE_LEN;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]                           r_state;
  logic [SINGLE_LEN-1:0]                r_lw;
  logic [SINGLE_LEN-1:0]                r_col;
  logic [TOT_W-1:0]                     r_total;
  logic [TOT_W-1:0]                     r_req_cnt;
  logic [TOT_W-1:0]                     r_wr_cnt;
  logic [BANK_W-1:0]                    r_bank;
  logic [ADDR_LEN-1:0]                  r_base;
  // [0]: FIFO data on the bus this cycle, [1]: BP write visible this cycle
  logic [1:0]                           r_vld_pipe;
  logic [ADDR_LEN-1:0]                  r_addr;
  logic [X_MESH-1:0][DATA_LEN-1:0]      r_data;
  logic [BANK_W-1:0]                    r_wbank;
  logic [DDR_ADDR_LEN-1:0]              r_ddr_addr;
  logic [SINGLE_LEN-1:0]                r_ddr_len;
  logic                                 r_ddr_conf;
  logic                                 r_done;
  logic                                 r_conf_err;

  logic                                 w_req;
  logic [TOT_W-1:0]                     w_total;
  logic [TOT_W-1:0]                     w_bytes;

  assign w_total = TOT_W'(bus.line_width) * TOT_W'(bus.line_num);
  assign w_bytes = w_total * TOT_W'(WORD_BYTES);

  // Combinational from registered state so a request never lands on an empty FIFO.
  assign w_req = (r_state == S_STREAM) && !bus.ddr_fifo_empty && (r_req_cnt < r_total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lw       <= '0;
      r_col      <= '0;
      r_total    <= '0;
      r_req_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_bank     <= '0;
      r_base     <= '0;
      r_vld_pipe <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wbank    <= '0;
      r_ddr_addr <= '0;
      r_ddr_len  <= '0;
      r_ddr_conf <= 1'b0;
      r_done     <= 1'b0;
      r_conf_err <= 1'b0;
    end else begin
      r_ddr_conf <= 1'b0;
      r_done     <= 1'b0;
      r_conf_err <= bus.conf && (r_state != S_IDLE);
      r_vld_pipe <= {r_vld_pipe[0], w_req};
      r_req_cnt  <= r_req_cnt + TOT_W'(w_req);

      if (r_vld_pipe[0]) begin
        r_addr   <= r_base + ADDR_LEN'(r_col);
        r_data   <= bus.ddr_fifo_data;
        r_wbank  <= r_bank;
        r_wr_cnt <= r_wr_cnt + TOT_W'(1);
        if (r_col == r_lw - SINGLE_LEN'(1)) begin
          r_col  <= '0;
          r_bank <= (r_bank == BANK_W'(X_MAC - 1)) ? '0 : r_bank + BANK_W'(1);
          if (r_bank == BANK_W'(X_MAC - 1))
            r_base <= r_base + ADDR_LEN'(r_lw);
        end else begin
          r_col <= r_col + SINGLE_LEN'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.conf) begin
            if (bus.line_width != '0 && bus.line_num != '0) begin
              r_lw       <= bus.line_width;
              r_total    <= w_total;
              r_col      <= '0;
              r_bank     <= bus.bp_st_bank;
              r_base     <= bus.bp_st_addr;
              r_req_cnt  <= '0;
              r_wr_cnt   <= '0;
              r_ddr_addr <= bus.ddr_st_addr;
              r_ddr_len  <= w_bytes[SINGLE_LEN-1:0];
              r_ddr_conf <= 1'b1;
              r_state    <= S_STREAM;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_STREAM: if (r_req_cnt == r_total) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (r_wr_cnt == r_total) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ddr_fifo_req    = w_req;
  assign bus.ddr_st_addr_out = r_ddr_addr;
  assign bus.ddr_len         = r_ddr_len;
  assign bus.ddr_conf        = r_ddr_conf;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.done            = r_done;
  assign bus.conf_err        = r_conf_err;

  // Bank g + X_MAC*m takes lane m; all banks share one address.
  for (genvar m = 0; m < X_MESH; m++) begin : g_col
    for (genvar g = 0; g < X_MAC; g++) begin : g_grp
      localparam int B = g + X_MAC * m;
      assign bus.BP_wea[B]                           = r_vld_pipe[1] && (r_wbank == BANK_W'(g));
      assign bus.BP_addr_out[B*ADDR_LEN +: ADDR_LEN] = r_addr;
      assign bus.BP_data_out[B*DATA_LEN +: DATA_LEN] = r_data[m];
    end
  end
endmodule

// File: tb/tb_bp_line_loader.sv
// Randomized bench for bp_line_loader: FIFO model with empty gaps and a closed-form
// expected write list (bank/addr/data per word) compared against every BP write.
module tb_bp_line_loader;
  localparam int X_MAC      = 4;
  localparam int X_MESH     = 16;
  localparam int DATA_LEN   = 32;
  localparam int ADDR_LEN   = 16;
  localparam int BUF_N      = X_MAC * X_MESH;
  localparam int WORD_W     = DATA_LEN * X_MESH;
  localparam int WORD_BYTES = WORD_W / 8;

  logic clk;
  logic rst_n;

  bp_line_loader_if bus ();
  bp_line_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                  bank;
    logic [ADDR_LEN-1:0] addr;
    logic [WORD_W-1:0]   data;
  } wr_t;

  wr_t               exp_q[$];
  logic [WORD_W-1:0] fifo_q[$];

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, gap_pct = 0;
  bit   conf_nxt = 0, req_seen = 0;
  int   n_req, n_wr, n_dconf, n_done, n_err;
  int   first_req, first_wr, last_wr, done_cyc, dconf_cyc;
  logic busy_at_done, busy_at_lastwr;
  logic [31:0] got_daddr;
  logic [23:0] got_dlen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [BUF_N-1:0] wmask(input int b);
    logic [BUF_N-1:0] mk;
    mk = '0;
    for (int m = 0; m < X_MESH; m++) mk[b + X_MAC*m] = 1'b1;
    return mk;
  endfunction

  task automatic clr_stats();
    n_req = 0; n_wr = 0; n_dconf = 0; n_done = 0; n_err = 0;
    first_req = -1; first_wr = -1; last_wr = -1; done_cyc = -1; dconf_cyc = -1;
    busy_at_done = 1'bx; busy_at_lastwr = 1'bx;
    got_daddr = '0; got_dlen = '0;
  endtask

  // Sample outputs on the falling edge, then drive the next cycle's inputs just after the rise.
  task automatic step();
    wr_t e;
    @(negedge clk);
    cyc++;
    req_seen = bus.ddr_fifo_req;
    if (bus.ddr_fifo_req) begin
      chk("req_while_empty", bus.ddr_fifo_empty, 1'b0);
      n_req++;
      if (first_req < 0) first_req = cyc;
    end
    if (bus.BP_wea != '0) begin
      n_wr++;
      last_wr = cyc;
      busy_at_lastwr = bus.busy;
      if (first_wr < 0) first_wr = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wea", bus.BP_wea, wmask(e.bank));
        chk("addr_b0", bus.BP_addr_out[ADDR_LEN-1:0], e.addr);
        chk("addr_bN", bus.BP_addr_out[BUF_N*ADDR_LEN-1 -: ADDR_LEN], e.addr);
        for (int m = 0; m < X_MESH; m++)
          chk($sformatf("data_l%0d", m),
              bus.BP_data_out[(e.bank + X_MAC*m)*DATA_LEN +: DATA_LEN],
              e.data[m*DATA_LEN +: DATA_LEN]);
      end
    end
    if (bus.ddr_conf) begin
      n_dconf++;
      dconf_cyc = cyc;
      got_daddr = bus.ddr_st_addr_out;
      got_dlen  = bus.ddr_len;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
    end
    if (bus.conf_err) n_err++;
    @(posedge clk);
    #1;
    bus.conf = conf_nxt;
    conf_nxt = 0;
    if (req_seen) bus.ddr_fifo_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
    bus.ddr_fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < gap_pct);
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < X_MESH; i++) w[i*DATA_LEN +: DATA_LEN] = $urandom();
    return w;
  endfunction

  // Expected write k: line k/lw lands in bank (st_bank+line) mod X_MAC, base advanced by
  // lw for every full pass over the banks.
  task automatic run_job(input logic [31:0] dst, input logic [15:0] sta, input int sbank,
                         input int lw, input int ln, input int gap, input int inj);
    int total, start, line, bs;
    wr_t e;
    total = lw * ln;
    clr_stats();
    gap_pct = gap;
    for (int k = 0; k < total; k++) begin
      line   = k / lw;
      bs     = sbank + line;
      e.bank = bs % X_MAC;
      e.addr = ADDR_LEN'(int'(sta) + (bs / X_MAC) * lw + (k % lw));
      e.data = rand_word();
      fifo_q.push_back(e.data);
      exp_q.push_back(e);
    end
    bus.ddr_st_addr = dst;
    bus.bp_st_addr  = sta;
    bus.bp_st_bank  = 2'(sbank);
    bus.line_width  = 24'(lw);
    bus.line_num    = 8'(ln);
    bus.conf        = 1'b1;
    start = cyc;
    for (int i = 1; i <= 3000 && n_done == 0; i++) begin
      if (i == inj) begin
        bus.line_width = 24'd5;
        bus.line_num   = 8'd3;
        conf_nxt       = 1;
      end
      step();
    end
    repeat (3) step();
    chk("done_cnt", n_done, 1);
    chk("busy_at_done", busy_at_done, 1'b0);
    chk("conf_err_cnt", n_err, (inj > 0) ? 1 : 0);
    if (total == 0) begin
      chk("zero_done_lat", done_cyc - (start + 1), 1);
      chk("zero_ddr_conf", n_dconf, 0);
      chk("zero_wr_cnt", n_wr, 0);
    end else begin
      chk("ddr_conf_cnt", n_dconf, 1);
      chk("ddr_conf_lat", dconf_cyc - (start + 1), 1);
      chk("ddr_addr", got_daddr, dst);
      chk("ddr_len", got_dlen, 24'(total * WORD_BYTES));
      chk("req_cnt", n_req, total);
      chk("wr_cnt", n_wr, total);
      chk("exp_left", exp_q.size(), 0);
      chk("first_wr_lat", first_wr - first_req, 2);
      chk("done_lat", done_cyc - last_wr, 1);
      chk("busy_last_wr", busy_at_lastwr, 1'b1);
    end
    exp_q.delete();
    fifo_q.delete();
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.conf           = 1'b0;
    bus.ddr_st_addr    = '0;
    bus.bp_st_addr     = '0;
    bus.bp_st_bank     = '0;
    bus.line_width     = '0;
    bus.line_num       = '0;
    bus.ddr_fifo_empty = 1'b1;
    bus.ddr_fifo_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ddr_conf", bus.ddr_conf, 1'b0);
    chk("rst_req", bus.ddr_fifo_req, 1'b0);
    chk("rst_wea", bus.BP_wea, '0);
    chk("rst_conf_err", bus.conf_err, 1'b0);
    chk("rst_ddr_len", bus.ddr_len, '0);
    rst_n = 1'b1;

    run_job(32'h1000, 16'h0010, 0, 3, 2, 0, 0);
    run_job(32'h2000, 16'h0000, 3, 2, 6, 0, 0);
    run_job(32'h2000, 16'h0000, 3, 2, 6, 50, 0);
    run_job(32'h3000, 16'hFFFF, 1, 2, 2, 0, 0);
    run_job(32'h1000, 16'h0010, 0, 3, 2, 0, 8);
    run_job(32'h1000, 16'h0040, 2, 4, 3, 0, 3);
    run_job(32'h4000, 16'h0020, 0, 3, 0, 0, 0);
    run_job(32'h4000, 16'h0020, 1, 0, 4, 0, 0);
    for (int j = 0; j < 6; j++)
      run_job($urandom(), 16'($urandom()), $urandom_range(0, 3),
              $urandom_range(1, 5), $urandom_range(1, 6), 50, (j == 2) ? 4 : 0);

    clr_stats();
    gap_pct = 30;
    for (int k = 0; k < 12; k++) fifo_q.push_back(rand_word());
    bus.ddr_st_addr = 32'h5000;
    bus.bp_st_addr  = 16'h0100;
    bus.bp_st_bank  = 2'd0;
    bus.line_width  = 24'd4;
    bus.line_num    = 8'd3;
    bus.conf        = 1'b1;
    repeat (6) step();
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.ddr_fifo_req, 1'b0);
    chk("mid_rst_wea", bus.BP_wea, '0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_addr", |bus.BP_addr_out, 1'b0);
    chk("mid_rst_data", |bus.BP_data_out, 1'b0);
    chk("mid_rst_ddr_addr", bus.ddr_st_addr_out, '0);
    fifo_q.delete();
    exp_q.delete();
    conf_nxt = 0;
    bus.conf = 1'b0;
    n_done   = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("rst_no_done", n_done, 0);
    run_job(32'h6000, 16'h0200, 2, 3, 3, 20, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
